crc_frame_arbiter: RTL and testbench
====================================

# crc_frame_arbiter

Round-robin front-end controller that shares the single CRC encoder between two byte-stream requesters. It grants the encoder to one requester per frame, forwards exactly FRAME_BYTES bytes with the encoder's start/push handshake, waits for the encoder's result push, and returns that result to the owning requester before re-arbitrating. It sits between the packet sources and the encoder input/output interface.

## Interface
- DW, 8, byte width of requester and encoder data.
- RW, 32, width of the encoder result word.
- FRAME_BYTES, 4, bytes per frame (2..8).
- TIMEOUT, 64, cycles allowed in WAIT_RES (used only with ARB_TIMEOUT_EN).
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req[1:0]  in  2  frame request per requester, held until gnt.
- push[1:0]  in  2  byte valid per requester.
- data0, data1  in  DW each  byte from requester 0 / 1.
- gnt[1:0]  out  2  one-hot grant, held for the whole frame.
- res_valid[1:0]  out  2  one-cycle result strobe to the owning requester.
- res_data  out  RW  result word, valid with res_valid.
- err[1:0]  out  2  one-cycle timeout strobe to the owner (0 without ARB_TIMEOUT_EN).
- enc_startin  out  1  frame-active to encoder.
- enc_pushin  out  1  byte valid to encoder.
- enc_datain  out  DW  byte to encoder.
- enc_pushout  in  1  encoder result valid.
- enc_dataout  in  RW  encoder result word.

## Operation
- States: IDLE, FEED, WAIT_RES, RESP.
- IDLE: if any req, pick winner (round robin: priority to requester != last_owner; after reset last_owner=1 so requester 0 wins ties), set gnt, clear byte count, go FEED.
- FEED: a push from the owner is registered onto enc_datain/enc_pushin with enc_startin=1; pushes from the non-owner are ignored. Byte counter (3 bits) increments per accepted push; on the FRAME_BYTES-th push, gnt clears and state goes WAIT_RES. Owner pushes in cycles with gnt=0 are ignored.
- enc_startin is high in every cycle enc_pushin is high for the frame; low otherwise.
- WAIT_RES: on enc_pushout, capture enc_dataout into res_data, go RESP. enc_pushout in any other state is ignored.
- RESP: res_valid[owner]=1 for one cycle, last_owner<=owner, go IDLE.
- req dropped while granted does not abort the frame.
- Reset (any state): gnt=0, res_valid=0, res_data=0, err=0, enc_startin=0, enc_pushin=0, enc_datain=0, count=0, last_owner=1, state IDLE.

## Timing
- req sampled high in IDLE at edge N -> gnt high after edge N.
- Owner push at edge M -> enc_pushin/enc_startin/enc_datain high after edge M (1-cycle latency), for exactly one cycle per push.
- Last byte push at edge L -> gnt low after L; enc_pushin for that byte after L.
- enc_pushout at edge R -> res_valid/res_data after R, one cycle; earliest next gnt after R+2.
- Minimum frame-to-frame gap: 2 idle cycles of gnt (RESP, IDLE).

## Configuration
- ARB_TIMEOUT_EN defined: an 8-bit watchdog counts cycles in WAIT_RES; reaching TIMEOUT without enc_pushout pulses err[owner] for one cycle, leaves res_valid low, updates last_owner, returns to IDLE.
- Not defined: no watchdog, err tied 0, WAIT_RES waits indefinitely.

## Test plan
- Single frame: req=01, bytes 11,22,33,44 with push every cycle -> enc_datain 11,22,33,44 on consecutive cycles with enc_startin=1; enc_pushout with 0xDEADBEEF -> res_valid=01, res_data=0xDEADBEEF one cycle later.
- Tie and fairness: req=11 from reset -> requester 0 granted first; after its result, requester 1 granted; with req=11 again, requester 0 next.
- Gapped pushes and intruder: owner 0 pushes with 2-cycle gaps while requester 1 pushes 0xFF every cycle -> encoder sees only requester 0's 4 bytes, never 0xFF; gnt held until the 4th.
- Spurious result: enc_pushout during IDLE and FEED -> no res_valid; only the WAIT_RES pulse is returned.
- Reset mid-FEED after 2 bytes -> all outputs 0 immediately; req=10 afterward -> requester 1 granted, full 4-byte frame.
- With ARB_TIMEOUT_EN, TIMEOUT=64: no enc_pushout -> err[owner] pulses 64 cycles after entering WAIT_RES, res_valid stays 0, next req granted.

Source files
------------

// File: rtl/crc_frame_arbiter.sv
// crc_frame_arbiter: round-robin front end that shares one CRC encoder between two byte requesters.
// Optional feature macro: ARB_TIMEOUT_EN adds a WAIT_RES watchdog that returns err[owner] after TIMEOUT cycles.
module crc_frame_arbiter #(
    parameter int DW          = 8,
    parameter int RW          = 32,
    parameter int FRAME_BYTES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [1:0]    push,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    output logic [1:0]    gnt,
    output logic [1:0]    res_valid,
    output logic [RW-1:0] res_data,
    output logic [1:0]    err,
    output logic          enc_startin,
    output logic          enc_pushin,
    output logic [DW-1:0] enc_datain,
    input  logic          enc_pushout,
    input  logic [RW-1:0] enc_dataout,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FEED     = 2'd1,
        WAIT_RES = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    state_t        state;
    state_t        state_n;
    logic          owner;
    logic          owner_n;
    logic          last_owner;
    logic          last_owner_n;
    logic [2:0]    count;
    logic [2:0]    count_n;
    logic [1:0]    gnt_n;
    logic [1:0]    res_valid_n;
    logic [RW-1:0] res_data_n;
    logic          enc_pushin_n;
    logic [DW-1:0] enc_datain_n;

    logic          winner;
    logic [1:0]    owner_onehot;
    logic [1:0]    winner_onehot;
    logic          owner_push;
    logic [DW-1:0] owner_data;

    // On a tie the requester that did not own the previous frame wins.
    assign winner        = (req == 2'b11) ? ~last_owner : req[1];
    assign winner_onehot = winner ? 2'b10 : 2'b01;
    assign owner_onehot  = owner ? 2'b10 : 2'b01;
    assign owner_push    = push[owner];
    assign owner_data    = owner ? data1 : data0;

    // The encoder sees the frame as active exactly on the cycles carrying a byte.
    assign enc_startin = enc_pushin;
    assign fsm_state   = state;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wdog;
    logic [7:0] wdog_n;
    logic [1:0] err_q;
    logic [1:0] err_n;

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign err            = 2'b00;
`endif

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        count_n      = count;
        gnt_n        = gnt;
        res_valid_n  = 2'b00;
        res_data_n   = res_data;
        enc_pushin_n = 1'b0;
        enc_datain_n = enc_datain;
`ifdef ARB_TIMEOUT_EN
        wdog_n       = wdog;
        err_n        = 2'b00;
`endif

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_n = winner;
                    gnt_n   = winner_onehot;
                    count_n = 3'd0;
                    state_n = FEED;
                end
            end

            FEED: begin
                if (owner_push) begin
                    enc_pushin_n = 1'b1;
                    enc_datain_n = owner_data;
                    count_n      = count + 3'd1;
                    if (count == LAST_IDX) begin
                        gnt_n   = 2'b00;
                        state_n = WAIT_RES;
`ifdef ARB_TIMEOUT_EN
                        wdog_n  = 8'd0;
`endif
                    end
                end
            end

            WAIT_RES: begin
                if (enc_pushout) begin
                    res_data_n  = enc_dataout;
                    res_valid_n = owner_onehot;
                    state_n     = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wdog == WDOG_LAST) begin
                    // Give up on the encoder: the owner gets an error instead of a result.
                    err_n        = owner_onehot;
                    last_owner_n = owner;
                    state_n      = IDLE;
                end else begin
                    wdog_n = wdog + 8'd1;
                end
`endif
            end

            RESP: begin
                last_owner_n = owner;
                state_n      = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            count      <= 3'd0;
            gnt        <= 2'b00;
            res_valid  <= 2'b00;
            res_data   <= '0;
            enc_pushin <= 1'b0;
            enc_datain <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            count      <= count_n;
            gnt        <= gnt_n;
            res_valid  <= res_valid_n;
            res_data   <= res_data_n;
            enc_pushin <= enc_pushin_n;
            enc_datain <= enc_datain_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog  <= 8'd0;
            err_q <= 2'b00;
        end else begin
            wdog  <= wdog_n;
            err_q <= err_n;
        end
    end
`endif

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// tb_crc_frame_arbiter: randomized frames through crc_frame_arbiter checked against a transaction-level model.
// The watchdog scenario is included when ARB_TIMEOUT_EN is defined.
module tb_crc_frame_arbiter;

    localparam int DW = 8;
    localparam int RW = 32;
    localparam int FB = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    push;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic [1:0]    gnt;
    logic [1:0]    res_valid;
    logic [RW-1:0] res_data;
    logic [1:0]    err;
    logic          enc_startin;
    logic          enc_pushin;
    logic [DW-1:0] enc_datain;
    logic          enc_pushout;
    logic [RW-1:0] enc_dataout;
    logic [1:0]    fsm_state;

    int errors = 0;
    int checks = 0;

    // Scoreboard: bytes the encoder should see, and what it actually saw (with cycle stamps).
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    int            obs_t[$];
    int            cyc = 0;
    int            rv_seen = 0;
    int            err_seen = 0;
    int            start_bad = 0;
    int            frames_done = 0;
    int            exp_err = 0;
    logic          model_last;

    always #5 clk = ~clk;

    crc_frame_arbiter #(
        .DW(DW), .RW(RW), .FRAME_BYTES(FB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .push(push),
        .data0(data0), .data1(data1), .gnt(gnt), .res_valid(res_valid),
        .res_data(res_data), .err(err), .enc_startin(enc_startin),
        .enc_pushin(enc_pushin), .enc_datain(enc_datain),
        .enc_pushout(enc_pushout), .enc_dataout(enc_dataout), .fsm_state(fsm_state)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (enc_pushin === 1'b1) begin
            obs_q.push_back(enc_datain);
            obs_t.push_back(cyc);
        end
        if (enc_startin !== enc_pushin) start_bad++;
        if (res_valid !== 2'b00) rv_seen++;
        if (err !== 2'b00) err_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fairness rule: a lone requester wins; on a tie, the one that did not own the last frame wins.
    function automatic logic rr_pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) return !last;
        return r[1];
    endfunction

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
    endtask

    // Drives one complete frame for requester w and reports what was observed.
    task automatic do_frame(input logic [1:0] rq, input logic w, input int gap_lo, input int gap_hi,
                            input bit intruder, input bit fixed, input bit spurious,
                            input logic [RW-1:0] result, input int wait_cyc,
                            output logic [1:0] g_obs, output bit g_held, output bit g_drop,
                            output int first_cyc, output logic [1:0] rv_obs,
                            output logic [RW-1:0] rd_obs, output bit rv_once);
        logic [1:0]    oh;
        int            gap;
        logic [DW-1:0] b;
        clear_queues();
        oh        = w ? 2'b10 : 2'b01;
        g_held    = 1'b1;
        first_cyc = -1;
        req       = rq;
        step();
        g_obs  = gnt;
        req[w] = 1'b0;
        for (int i = 0; i < FB; i++) begin
            gap = $urandom_range(gap_hi, gap_lo);
            for (int k = 0; k < gap; k++) begin
                push     = 2'b00;
                push[!w] = intruder;
                data0    = 8'hFF;
                data1    = 8'hFF;
                step();
                if (gnt !== oh) g_held = 1'b0;
            end
            b = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(254, 0));
            data0 = 8'hFF;
            data1 = 8'hFF;
            if (w) data1 = b;
            else   data0 = b;
            push     = 2'b00;
            push[w]  = 1'b1;
            push[!w] = intruder;
            if (spurious && i == 0) begin
                enc_pushout = 1'b1;
                enc_dataout = $urandom;
            end
            exp_q.push_back(b);
            step();
            enc_pushout = 1'b0;
            if (i == 0) first_cyc = cyc;
            if (i < FB - 1 && gnt !== oh) g_held = 1'b0;
        end
        push   = 2'b00;
        g_drop = (gnt === 2'b00);
        for (int k = 0; k < wait_cyc; k++) step();
        enc_pushout = 1'b1;
        enc_dataout = result;
        step();
        enc_pushout = 1'b0;
        enc_dataout = $urandom;
        rv_obs  = res_valid;
        rd_obs  = res_data;
        step();
        rv_once = (res_valid === 2'b00) && (gnt === 2'b00);
        model_last = w;
        frames_done++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({gnt, res_valid, res_data, err, enc_startin, enc_pushin, enc_datain} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h err=%b st=%b pi=%b di=%h required all zero",
                     gnt, res_valid, res_data, err, enc_startin, enc_pushin, enc_datain);
        end
        reset = 1'b0;
        step();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_gnt: got %b required 00", gnt);
        end
    endtask

    task automatic test_single_frame();
        logic w; logic [1:0] g; bit held; bit drop; int fc; logic [1:0] rv; logic [RW-1:0] rd; bit once;
        w = rr_pick(2'b01, model_last);
        do_frame(2'b01, w, 0, 0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 2, g, held, drop, fc, rv, rd, once);
        checks++;
        if (g !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b required 01", g); end
        checks++;
        if (!held) begin errors++; $display("FAIL single_gnt_held: got 0 required 1"); end
        checks++;
        if (!drop) begin errors++; $display("FAIL single_gnt_drop: got 0 required 1"); end
        checks++;
        if (obs_q.size() != FB) begin
            errors++;
            $display("FAIL single_byte_count: got %0d required %0d", obs_q.size(), FB);
        end else begin
            for (int i = 0; i < FB; i++) begin
                checks++;
                if (obs_q[i] !== 8'(8'h11 * (i + 1))) begin
                    errors++;
                    $display("FAIL single_byte%0d: got %h required %h", i, obs_q[i], 8'(8'h11 * (i + 1)));
                end
                checks++;
                if (obs_t[i] != fc + i) begin
                    errors++;
                    $display("FAIL single_byte%0d_cycle: got %0d required %0d", i, obs_t[i], fc + i);
                end
            end
        end
        checks++;
        if (rv !== 2'b01) begin errors++; $display("FAIL single_res_valid: got %b required 01", rv); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL single_res_data: got %h required deadbeef", rd); end
        checks++;
        if (!once) begin errors++; $display("FAIL single_res_one_cycle: got 0 required 1"); end
    endtask

    task automatic test_fairness();
        logic w; logic [1:0] g; bit held; bit drop; int fc; logic [1:0] rv; logic [RW-1:0] rd; bit once;
        logic [1:0] rq; logic [RW-1:0] res; logic [1:0] oh;
        logic [1:0] plan[3];
        plan[0] = 2'b11;
        plan[1] = 2'b00;
        plan[2] = 2'b11;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_last = 1'b1;
        req = 2'b00;
        step();
        for (int f = 0; f < 3; f++) begin
            rq  = plan[f] | req;
            w   = rr_pick(rq, model_last);
            oh  = w ? 2'b10 : 2'b01;
            res = $urandom;
            do_frame(rq, w, 0, 1, 1'b0, 1'b0, 1'b0, res, $urandom_range(3, 0), g, held, drop, fc, rv, rd, once);
            checks++;
            if (g !== oh) begin errors++; $display("FAIL fair_gnt%0d: got %b required %b", f, g, oh); end
            checks++;
            if (rv !== oh || rd !== res) begin
                errors++;
                $display("FAIL fair_res%0d: got %b/%h required %b/%h", f, rv, rd, oh, res);
            end
            checks++;
            if (!once) begin errors++; $display("FAIL fair_gap%0d: got early grant or long res_valid", f); end
        end
        req = 2'b00;
    endtask

    task automatic test_gapped_intruder();
        logic w; logic [1:0] g; bit held; bit drop; int fc; logic [1:0] rv; logic [RW-1:0] rd; bit once;
        logic [RW-1:0] res;
        w   = rr_pick(2'b01, model_last);
        res = $urandom;
        do_frame(2'b01, w, 2, 2, 1'b1, 1'b0, 1'b0, res, 1, g, held, drop, fc, rv, rd, once);
        checks++;
        if (!held) begin errors++; $display("FAIL gap_gnt_held: got 0 required 1"); end
        checks++;
        if (!drop) begin errors++; $display("FAIL gap_gnt_drop: got 0 required 1"); end
        checks++;
        if (obs_q.size() != FB) begin
            errors++;
            $display("FAIL gap_byte_count: got %0d required %0d", obs_q.size(), FB);
        end else begin
            for (int i = 0; i < FB; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL gap_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rv !== 2'b01 || rd !== res) begin
            errors++;
            $display("FAIL gap_res: got %b/%h required 01/%h", rv, rd, res);
        end
    endtask

    task automatic test_spurious();
        logic w; logic [1:0] g; bit held; bit drop; int fc; logic [1:0] rv; logic [RW-1:0] rd; bit once;
        logic [RW-1:0] res; int rv0;
        rv0 = rv_seen;
        enc_pushout = 1'b1;
        enc_dataout = 32'hBADBAD00;
        step();
        enc_pushout = 1'b0;
        step();
        checks++;
        if (res_valid !== 2'b00) begin errors++; $display("FAIL spur_idle_rv: got %b required 00", res_valid); end
        w   = rr_pick(2'b10, model_last);
        res = $urandom;
        do_frame(2'b10, w, 0, 2, 1'b0, 1'b0, 1'b1, res, 3, g, held, drop, fc, rv, rd, once);
        checks++;
        if (rv_seen - rv0 != 1) begin
            errors++;
            $display("FAIL spur_pulse_count: got %0d required 1", rv_seen - rv0);
        end
        checks++;
        if (rv !== 2'b10 || rd !== res) begin
            errors++;
            $display("FAIL spur_res: got %b/%h required 10/%h", rv, rd, res);
        end
    endtask

    task automatic test_reset_mid();
        logic w; logic [1:0] g; bit held; bit drop; int fc; logic [1:0] rv; logic [RW-1:0] rd; bit once;
        logic [RW-1:0] res;
        req = 2'b01;
        step();
        req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            push  = 2'b01;
            data0 = 8'($urandom_range(254, 1));
            step();
        end
        push  = 2'b00;
        reset = 1'b1;
        #2;
        checks++;
        if ({gnt, res_valid, res_data, err, enc_startin, enc_pushin, enc_datain} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got gnt=%b rv=%b rd=%h err=%b st=%b pi=%b di=%h required all zero",
                     gnt, res_valid, res_data, err, enc_startin, enc_pushin, enc_datain);
        end
        step();
        reset = 1'b0;
        model_last = 1'b1;
        step();
        w   = rr_pick(2'b10, model_last);
        res = $urandom;
        do_frame(2'b10, w, 0, 1, 1'b0, 1'b0, 1'b0, res, 0, g, held, drop, fc, rv, rd, once);
        checks++;
        if (g !== 2'b10) begin errors++; $display("FAIL midreset_gnt: got %b required 10", g); end
        checks++;
        if (obs_q.size() != FB) begin
            errors++;
            $display("FAIL midreset_byte_count: got %0d required %0d", obs_q.size(), FB);
        end else begin
            for (int i = 0; i < FB; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL midreset_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rv !== 2'b10 || rd !== res) begin
            errors++;
            $display("FAIL midreset_res: got %b/%h required 10/%h", rv, rd, res);
        end
    endtask

    task automatic test_random();
        logic w; logic [1:0] g; bit held; bit drop; int fc; logic [1:0] rv; logic [RW-1:0] rd; bit once;
        logic [1:0] rq; logic [1:0] oh; logic [RW-1:0] res; int bad;
        for (int f = 0; f < 10; f++) begin
            rq  = req | 2'($urandom_range(3, 1));
            w   = rr_pick(rq, model_last);
            oh  = w ? 2'b10 : 2'b01;
            res = $urandom;
            do_frame(rq, w, 0, 3, bit'($urandom_range(1, 0)), 1'b0, bit'($urandom_range(1, 0)),
                     res, $urandom_range(5, 0), g, held, drop, fc, rv, rd, once);
            checks++;
            if (g !== oh || !held || !drop) begin
                errors++;
                $display("FAIL rand_gnt%0d: got %b held=%0d drop=%0d required %b 1 1", f, g, held, drop, oh);
            end
            bad = (obs_q.size() != FB) ? 1 : 0;
            for (int i = 0; i < FB && bad == 0; i++) if (obs_q[i] !== exp_q[i]) bad = 1;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_bytes%0d: got %p required %p", f, obs_q, exp_q);
            end
            checks++;
            if (rv !== oh || rd !== res || !once) begin
                errors++;
                $display("FAIL rand_res%0d: got %b/%h once=%0d required %b/%h 1", f, rv, rd, once, oh, res);
            end
        end
        req = 2'b00;
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic w; logic [1:0] g; bit held; bit drop; int fc; logic [1:0] rv; logic [RW-1:0] rd; bit once;
        logic [1:0] oh; int k; int r0; logic [1:0] err_obs; logic [RW-1:0] res;
        w  = rr_pick(2'b01, model_last);
        oh = w ? 2'b10 : 2'b01;
        req = 2'b01;
        step();
        req = 2'b00;
        for (int i = 0; i < FB; i++) begin
            push  = 2'b01;
            data0 = 8'($urandom);
            step();
        end
        push = 2'b00;
        r0   = rv_seen;
        k    = 0;
        while (err === 2'b00 && k < 4 * TO) begin
            step();
            k++;
        end
        err_obs = err;
        checks++;
        if (k != TO) begin errors++; $display("FAIL timeout_latency: got %0d required %0d", k, TO); end
        checks++;
        if (err_obs !== oh) begin errors++; $display("FAIL timeout_err: got %b required %b", err_obs, oh); end
        step();
        checks++;
        if (err !== 2'b00 || rv_seen != r0) begin
            errors++;
            $display("FAIL timeout_after: got err=%b rv_pulses=%0d required 00 0", err, rv_seen - r0);
        end
        model_last = w;
        exp_err++;
        w   = rr_pick(2'b11, model_last);
        oh  = w ? 2'b10 : 2'b01;
        res = $urandom;
        do_frame(2'b11, w, 0, 1, 1'b0, 1'b0, 1'b0, res, 0, g, held, drop, fc, rv, rd, once);
        checks++;
        if (g !== oh || rv !== oh || rd !== res) begin
            errors++;
            $display("FAIL timeout_next: got %b/%b/%h required %b/%b/%h", g, rv, rd, oh, oh, res);
        end
        req = 2'b00;
        step();
    endtask
`endif

    initial begin
        reset       = 1'b1;
        req         = 2'b00;
        push        = 2'b00;
        data0       = '0;
        data1       = '0;
        enc_pushout = 1'b0;
        enc_dataout = '0;
        model_last  = 1'b1;

        test_reset();
        test_single_frame();
        test_fairness();
        test_gapped_intruder();
        test_spurious();
        test_reset_mid();
        test_random();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        step();
        checks++;
        if (rv_seen != frames_done) begin
            errors++;
            $display("FAIL total_results: got %0d required %0d", rv_seen, frames_done);
        end
        checks++;
        if (err_seen != exp_err) begin
            errors++;
            $display("FAIL total_err_pulses: got %0d required %0d", err_seen, exp_err);
        end
        checks++;
        if (start_bad != 0) begin
            errors++;
            $display("FAIL startin_vs_pushin: got %0d differing cycles required 0", start_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
